// File: rtl/cache_pkg.sv
// cache_pkg: bus-wide types and widths shared by the cache and the memory
// model that sits downstream of it on the MemBus.
package cache_pkg;

  parameter int ADDR_WIDTH = 8;
  parameter int DATA_WIDTH = 32;

  // Request opcode on the downstream MemBus; only READ and WRITE are requests.
  typedef enum logic [1:0] {
    Op_NONE  = 2'd0,
    Op_READ  = 2'd1,
    Op_WRITE = 2'd2,
    Op_RSVD  = 2'd3
  } op_t;

endpackage : cache_pkg

// File: rtl/backing_memory_if.sv
// backing_memory_if: downstream MemBus between the cache (master) and the
// backing memory (slave). Requests flow down, responses and status flow up.
interface backing_memory_if;
  import cache_pkg::*;

  op_t                   req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  overflow;

  modport master (
    output req_op, req_addr, req_data,
    input  rsp_vld, rsp_data, overflow
  );

  modport slave (
    input  req_op, req_addr, req_data,
    output rsp_vld, rsp_data, overflow
  );

endinterface : backing_memory_if

// File: rtl/backing_memory.sv
// backing_memory: word-addressed main-memory model behind the cache.
// Accepts one READ/WRITE per cycle without backpressure, queues requests in
// arrival order, and completes each LATENCY cycles after its service starts.
// READs answer with a one-cycle rsp_vld pulse; WRITEs are silent.
// Optional feature macro: BACKING_MEMORY_RESET_CLEAR_EN -- when defined, rst
// also clears every memory word; otherwise memory contents survive rst.
module backing_memory
  import cache_pkg::*;
#(
  parameter int LATENCY     = 4,  // 1..15
  parameter int QUEUE_DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  backing_memory_if.slave  bus
);

  localparam int              PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int              MEM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    op_t                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Request queue (circular buffer)
  entry_t           r_queue [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  // Service engine
  state_t           r_state;
  logic [3:0]       r_cnt;
  entry_t           r_cur;

  // Storage and registered outputs
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic                  r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_overflow;

  // Decode of this edge's decisions
  entry_t w_in;
  entry_t w_next;
  logic   w_in_vld;
  logic   w_q_empty;
  logic   w_q_full;
  logic   w_eng_free;
  logic   w_take;
  logic   w_pop;
  logic   w_bypass;
  logic   w_push;
  logic   w_drop;
  logic   w_mem_we;

  assign w_in = '{op: bus.req_op, addr: bus.req_addr, data: bus.req_data};

  // A request on a reset edge is ignored, so rst gates every downstream decision.
  assign w_in_vld   = !rst && ((bus.req_op == Op_READ) || (bus.req_op == Op_WRITE));
  assign w_q_empty  = (r_count == '0);
  assign w_q_full   = (r_count == CNT_FULL);

  // The engine can accept new work when idle or on the edge its current request completes.
  assign w_eng_free = (r_state == S_IDLE) || (r_cnt == 4'd0);
  assign w_take     = !rst && w_eng_free && (!w_q_empty || w_in_vld);
  assign w_pop      = w_take && !w_q_empty;
  assign w_bypass   = w_take && w_q_empty;

  // Oldest first: the queue head wins over the incoming request.
  assign w_next     = w_q_empty ? w_in : r_queue[r_rd_ptr];

  // Anything not bypassed is pushed; a full queue still accepts when it pops on the same edge.
  assign w_push     = w_in_vld && !w_bypass && (!w_q_full || w_pop);
  assign w_drop     = w_in_vld && !w_bypass && w_q_full && !w_pop;

  // An in-flight write abandoned by reset must not reach memory.
  assign w_mem_we   = !rst && (r_state == S_BUSY) && (r_cnt == 4'd0) &&
                      (r_cur.op == Op_WRITE);

  // Queue slot write; occupancy is tracked by the pointer block.
  // NOTE: storage arrays carry no reset -- validity lives in r_count, so
  // clearing slots would only add reset fan-out with no functional effect.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_queue[r_wr_ptr] <= w_in;
    end
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Service engine FSM with registered response outputs.
  // NOTE: every register here uses <= so all reads within the block see
  // pre-edge values, matching the flop behaviour being modelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_cur      <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_cur   <= w_next;
            r_cnt   <= CNT_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_cur.op == Op_READ) begin
              r_rsp_vld  <= 1'b1;
              r_rsp_data <= r_mem[r_cur.addr];
            end
            if (w_take) begin
              r_cur <= w_next;
              r_cnt <= CNT_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BACKING_MEMORY_RESET_CLEAR_EN
  // Memory array: reset wipes every word, otherwise commit completing writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[r_cur.addr] <= r_cur.data;
    end
  end
`else
  // Memory array: commit completing writes; contents survive reset so a
  // cache reset does not lose main-memory state.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_cur.addr] <= r_cur.data;
    end
  end
`endif

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.rsp_vld  = r_rsp_vld;
  assign bus.rsp_data = r_rsp_data;
  assign bus.overflow = r_overflow;

endmodule : backing_memory

// File: tb/tb_backing_memory.sv
// tb_backing_memory: directed checks of the backing memory at LATENCY=4,
// QUEUE_DEPTH=4. Edges are numbered from the first step after each
// log restart; a response seen after edge N is logged as edge N.
module tb_backing_memory;
  import cache_pkg::*;

`ifdef BACKING_MEMORY_RESET_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  backing_memory_if bus ();

  backing_memory #(
    .LATENCY     (4),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;
  int                    rsp_edge [$];
  logic [DATA_WIDTH-1:0] rsp_dat  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one edge's inputs, clock, then sample and log any response.
  task automatic step(input op_t op, input logic [ADDR_WIDTH-1:0] a,
                      input logic [DATA_WIDTH-1:0] d, input logic r);
    rst          = r;
    bus.req_op   = op;
    bus.req_addr = a;
    bus.req_data = d;
    @(posedge clk);
    #1;
    if (bus.rsp_vld === 1'b1) begin
      rsp_edge.push_back(edge_no);
      rsp_dat.push_back(bus.rsp_data);
    end
    edge_no++;
    rst          = 1'b0;
    bus.req_op   = Op_NONE;
    bus.req_addr = '0;
    bus.req_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(Op_NONE, '0, '0, 1'b0);
  endtask

  task automatic restart_log();
    edge_no = 0;
    rsp_edge.delete();
    rsp_dat.delete();
  endtask

  // Compare the logged responses with expected edges and data.
  task automatic check_rsps(input string tag, input int n, input int exp_edge [8],
                            input logic [DATA_WIDTH-1:0] exp_dat [8]);
    check({tag, "_count"}, 32'(rsp_edge.size()), 32'(n));
    for (int i = 0; i < n && i < rsp_edge.size(); i++) begin
      check($sformatf("%s_edge%0d", tag, i), 32'(rsp_edge[i]), 32'(exp_edge[i]));
      check($sformatf("%s_data%0d", tag, i), rsp_dat[i], exp_dat[i]);
    end
  endtask

  initial begin
    int                    e_edge [8];
    logic [DATA_WIDTH-1:0] e_dat  [8];

    rst          = 1'b1;
    bus.req_op   = Op_NONE;
    bus.req_addr = '0;
    bus.req_data = '0;

    // Reset state
    step(Op_NONE, '0, '0, 1'b1);
    step(Op_NONE, '0, '0, 1'b1);
    check("rst_vld",  32'(bus.rsp_vld),  32'h0);
    check("rst_data", bus.rsp_data,      32'h0);
    check("rst_ovf",  32'(bus.overflow), 32'h0);

    // Unloaded write then read: response only after edge 14
    restart_log();
    step(Op_WRITE, 8'h05, 32'hAB, 1'b0);
    idle(9);
    step(Op_READ, 8'h05, '0, 1'b0);
    idle(10);
    e_edge[0] = 14; e_dat[0] = 32'hAB;
    check_rsps("unloaded", 1, e_edge, e_dat);
    check("hold_vld",  32'(bus.rsp_vld), 32'h0);
    check("hold_data", bus.rsp_data,     32'hAB);

    // Writeback-then-fill pair
    restart_log();
    step(Op_WRITE, 8'h12, 32'h77, 1'b0);
    step(Op_READ,  8'h12, '0,     1'b0);
    idle(11);
    e_edge[0] = 8; e_dat[0] = 32'h77;
    check_rsps("wb_pair", 1, e_edge, e_dat);

    // Prefill addresses 0..5 with distinct data
    for (int i = 0; i < 6; i++) begin
      step(Op_WRITE, ADDR_WIDTH'(i), 32'(32'hC0 + i), 1'b0);
      idle(4);
    end

    // Burst of 6 reads, plus one more on the edge the full queue pops
    restart_log();
    for (int i = 0; i < 6; i++) step(Op_READ, ADDR_WIDTH'(i), '0, 1'b0);
    idle(2);
    step(Op_READ, 8'h00, '0, 1'b0);
    idle(25);
    for (int i = 0; i < 6; i++) begin
      e_edge[i] = 4 * (i + 1);
      e_dat[i]  = 32'(32'hC0 + i);
    end
    e_edge[6] = 28; e_dat[6] = 32'hC0;
    check_rsps("burst6", 7, e_edge, e_dat);
    check("burst6_ovf", 32'(bus.overflow), 32'h0);

    // Burst of 7 reads: the 7th is dropped
    restart_log();
    for (int i = 0; i < 6; i++) step(Op_READ, ADDR_WIDTH'(i), '0, 1'b0);
    check("burst7_ovf_before", 32'(bus.overflow), 32'h0);
    step(Op_READ, 8'h06, '0, 1'b0);
    check("burst7_ovf_set", 32'(bus.overflow), 32'h1);
    idle(25);
    check_rsps("burst7", 6, e_edge, e_dat);
    check("burst7_ovf_sticky", 32'(bus.overflow), 32'h1);

    // Reset mid-operation, with a read presented on the reset edge
    restart_log();
    step(Op_READ, 8'h00, '0, 1'b0);
    idle(1);
    step(Op_READ, 8'h02, '0, 1'b1);
    check("midrst_vld",  32'(bus.rsp_vld),  32'h0);
    check("midrst_data", bus.rsp_data,      32'h0);
    check("midrst_ovf",  32'(bus.overflow), 32'h0);
    idle(10);
    check("midrst_no_rsp", 32'(rsp_edge.size()), 32'h0);

    // Read after reset behaves as unloaded
    restart_log();
    step(Op_READ, 8'h01, '0, 1'b0);
    idle(8);
    e_edge[0] = 4; e_dat[0] = CLEAR_EN ? 32'h0 : 32'hC1;
    check_rsps("post_rst", 1, e_edge, e_dat);

    // Retention across reset
    step(Op_WRITE, 8'h03, 32'h5A, 1'b0);
    idle(5);
    step(Op_NONE, '0, '0, 1'b1);
    restart_log();
    step(Op_READ, 8'h03, '0, 1'b0);
    idle(6);
    e_edge[0] = 4; e_dat[0] = CLEAR_EN ? 32'h0 : 32'h5A;
    check_rsps("retain", 1, e_edge, e_dat);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_backing_memory
